perf_retire_counter: RTL
========================

// Module: perf_retire_counter
// PURPOSE
// Synthesizable retirement/cycle performance counter for the 4-lane core. It
// watches the per-lane commit valids from writeback and accumulates cycle,
// total-instruction and per-lane counts. On halt it drains the pipeline, then
// pulses per-lane report strobes into the simulation IPC monitor that sits
// directly downstream. A polled read port exposes counter snapshots.
// PARAMETERS
// LANES         4   number of commit lanes (rd_sel map below is fixed for 4)
// CNT_W         48  counter width; counters saturate, they never wrap
// DRAIN_CYCLES  8   cycles counted after first halt before the report fires
// PORTS
// clock       in   1        single core clock, rising edge
// reset_n     in   1        asynchronous, active-low reset
// start       in   1        begin measurement: counters cleared, enter RUN
// clear       in   1        synchronous abort: counters cleared, go to IDLE
// retire_vld  in   LANES    lane i committed one instruction this cycle
// halt        in   LANES    lane i committed a halt this cycle
// report      out  LANES    1-cycle strobe per halted lane (to IPC monitor)
// done        out  1        high while in DONE
// rd_req      in   1        read request
// rd_sel      in   3        0 cycles, 1 total instr, 2..5 lane0..3 instr, 6 status, 7 zero
// rd_ack      out  1        1-cycle strobe, rd_data valid from this cycle on
// rd_data     out  CNT_W    snapshot; status = {zero-pad, ovf, state[2:0]}
// BEHAVIOUR
// - Reset: state IDLE, all counters 0, ovf 0, report 0, done 0, rd_ack 0, rd_data 0.
// - FSM IDLE->RUN on start. RUN->DRAIN on |halt. DRAIN->REPORT when drain_cnt
//   reaches 0. REPORT->DONE unconditionally (REPORT lasts exactly one cycle).
//   DONE->RUN on start. Any state->IDLE on clear.
// - Priority per cycle: clear > start > halt. start in RUN/DRAIN restarts RUN
//   with counters cleared. halt is ignored outside RUN.
// - Entering RUN: all counters load 0 and ovf clears. Counting begins the
//   cycle after start.
// - RUN and DRAIN: cycle_cnt += 1; lane_cnt[i] += retire_vld[i];
//   instr_cnt += popcount(retire_vld), zero-extended to CNT_W. A retire in
//   the same cycle as halt is counted.
// - DRAIN: drain_cnt loads DRAIN_CYCLES-1 on entry and decrements each cycle.
//   The DRAIN cycles are counted. Further halts OR into halt_mask. With
//   DRAIN_CYCLES=0, DRAIN lasts one cycle.
// - halt_mask: loaded from halt on the RUN->DRAIN transition. report =
//   halt_mask for the single REPORT cycle, else 0.
// - IDLE, REPORT and DONE: counters frozen. done=1 only in DONE.
// - Saturation: a counter at all-ones holds and sets sticky ovf. ovf clears
//   only on reset, clear, or entry to RUN.
// - Read: a request is accepted when rd_req=1 and rd_ack=0. Next cycle:
//   rd_ack=1, rd_data = selected value sampled in the accept cycle. rd_data
//   holds until the next accepted read. Holding rd_req high yields an ack
//   every other cycle. Reads are legal in every state and never disturb
//   counting. clear does not cancel an in-flight ack.
// - Reset mid-operation: immediate return to reset values. No report pulse
//   is emitted.
// STRUCTURE
// - Shared package perf_pkg:
//   - state enum IDLE/RUN/DRAIN/REPORT/DONE (3-bit encoding, also used in status)
//   - rd_sel code constants
//   - CNT_W default
// - Sub-module sat_counter (CNT_W wide, inputs clr, en, inc[2:0], outputs
//   q and sat), instantiated LANES+2 times.
// - Top holds the FSM, drain counter, halt_mask, popcount, read mux and
//   read register.
// TESTING
// - Reset, start, then 10 cycles with retire_vld=4'b1111, then halt=4'b0001
//   with DRAIN_CYCLES=8 and retire_vld=0 in drain -> report=4'b0001 for one
//   cycle; cycles read 19; total instr read 40; lane0..3 each 10.
// - In DRAIN, assert halt=4'b0100 -> report=4'b0101. Halt in IDLE -> no
//   state change.
// - Same cycle start=1, clear=1 in DONE -> IDLE, all counters read 0.
// - CNT_W=4, retire_vld=4'b1111 for 5 cycles -> total instr reads 15, ovf=1
//   in status; start clears ovf.
// - Hold rd_req=1 with rd_sel=0 in RUN -> rd_ack on alternate cycles;
//   successive values differ by 2.
// - Deassert reset_n during DRAIN -> report stays 0, state IDLE, rd_data 0.
//   After release, start produces a normal run.

Source files
------------

// File: rtl/perf_pkg.sv
// ---------------------------------------------------------------------------
// perf_pkg
// Shared definitions for the retirement performance counter:
//   - state_t      : FSM state encoding (3 bits, also reported in the status word)
//   - SEL_*        : read-select codes for the polled read port
//   - CNT_W_DEF    : default counter width
// ---------------------------------------------------------------------------
package perf_pkg;

    localparam int CNT_W_DEF = 48;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] SEL_CYCLES = 3'd0;
    localparam logic [2:0] SEL_INSTR  = 3'd1;
    localparam logic [2:0] SEL_LANE0  = 3'd2;
    localparam logic [2:0] SEL_STATUS = 3'd6;
    localparam logic [2:0] SEL_ZERO   = 3'd7;

endpackage

// File: rtl/perf_retire_counter_sat.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for every performance count.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous clear to zero (wins over i_en)
//   i_en           : add i_inc this cycle
//   i_inc[2:0]     : increment amount (0..4 for a 4-lane popcount)
//   o_q            : current count; holds at all-ones once reached
//   o_sat          : this cycle's increment would have passed all-ones
// ---------------------------------------------------------------------------
module sat_counter
    import perf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [2:0]       i_inc,
    output logic [CNT_W-1:0] o_q,
    output logic             o_sat
);

    logic [CNT_W-1:0] r_q;
    logic [CNT_W:0]   w_sum;

    // One extra bit catches the carry; a carry means the true value passed all-ones.
    assign w_sum = {1'b0, r_q} + {{(CNT_W-2){1'b0}}, i_inc};
    assign o_sat = i_en & ~i_clr & w_sum[CNT_W];
    assign o_q   = r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/perf_retire_counter.sv
// ---------------------------------------------------------------------------
// perf_retire_counter
// Cycle / retired-instruction / per-lane performance counter for the 4-lane
// core. Counts while measuring, drains after the first halt, then pulses one
// report strobe per halted lane to the downstream IPC monitor.
// Ports:
//   i_clock, i_reset_n : core clock, asynchronous active-low reset
//   i_start            : clear counters and begin measuring (RUN)
//   i_clear            : clear counters and return to IDLE (highest priority)
//   i_retire_vld       : per-lane commit valid
//   i_halt             : per-lane halt commit
//   o_report           : one-cycle per-lane strobe in REPORT
//   o_done             : high while in DONE
//   i_rd_req, i_rd_sel : polled read request and select
//   o_rd_ack           : one-cycle read acknowledge
//   o_rd_data          : snapshot captured in the accept cycle
// ---------------------------------------------------------------------------
module perf_retire_counter
    import perf_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic [LANES-1:0] i_retire_vld,
    input  logic [LANES-1:0] i_halt,
    output logic [LANES-1:0] o_report,
    output logic             o_done,
    input  logic             i_rd_req,
    input  logic [2:0]       i_rd_sel,
    output logic             o_rd_ack,
    output logic [CNT_W-1:0] o_rd_data
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    // DRAIN_CYCLES=0 still spends one cycle in DRAIN.
    localparam logic [DW-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;

    state_t           r_state, w_state_nxt;
    logic [DW-1:0]    r_drain_cnt;
    logic [LANES-1:0] r_halt_mask;
    logic             r_ovf;
    logic             r_rd_ack;
    logic [CNT_W-1:0] r_rd_data;

    logic             w_go_run, w_clr, w_en, w_accept;
    logic [2:0]       w_pop;
    logic [CNT_W-1:0] w_cyc_q, w_instr_q, w_rd_mux;
    logic [CNT_W-1:0] w_lane_q [LANES];
    logic [LANES+1:0] w_sat;

    // REPORT always moves on to DONE, so a start there is not honoured.
    assign w_go_run = i_start & (r_state != ST_REPORT);
    assign w_clr    = i_clear | w_go_run;
    assign w_en     = ((r_state == ST_RUN) | (r_state == ST_DRAIN)) & ~w_clr;

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = ST_IDLE;
        end else if (w_go_run) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:    if (|i_halt) w_state_nxt = ST_DRAIN;
                ST_DRAIN:  if (r_drain_cnt == '0) w_state_nxt = ST_REPORT;
                ST_REPORT: w_state_nxt = ST_DONE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_drain_cnt <= '0;
            r_halt_mask <= '0;
        end else if ((r_state == ST_RUN) && (w_state_nxt == ST_DRAIN)) begin
            r_drain_cnt <= DRAIN_LOAD;
            r_halt_mask <= i_halt;
        end else if (r_state == ST_DRAIN) begin
            // Wraps harmlessly on the last DRAIN cycle; the state leaves DRAIN.
            r_drain_cnt <= r_drain_cnt - 1'b1;
            r_halt_mask <= r_halt_mask | i_halt;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + {2'b00, i_retire_vld[i]};
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cyc (
        .i_clk(i_clock), .i_rst_n(i_reset_n), .i_clr(w_clr), .i_en(w_en),
        .i_inc(3'd1), .o_q(w_cyc_q), .o_sat(w_sat[0])
    );

    sat_counter #(.CNT_W(CNT_W)) u_instr (
        .i_clk(i_clock), .i_rst_n(i_reset_n), .i_clr(w_clr), .i_en(w_en),
        .i_inc(w_pop), .o_q(w_instr_q), .o_sat(w_sat[1])
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sat_counter #(.CNT_W(CNT_W)) u_lane (
            .i_clk(i_clock), .i_rst_n(i_reset_n), .i_clr(w_clr), .i_en(w_en),
            .i_inc({2'b00, i_retire_vld[g]}), .o_q(w_lane_q[g]), .o_sat(w_sat[g+2])
        );
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_clr) begin
            r_ovf <= 1'b0;
        end else if (|w_sat) begin
            r_ovf <= 1'b1;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (i_rd_sel)
            SEL_CYCLES: w_rd_mux = w_cyc_q;
            SEL_INSTR:  w_rd_mux = w_instr_q;
            SEL_STATUS: w_rd_mux[3:0] = {r_ovf, r_state};
            SEL_ZERO:   w_rd_mux = '0;
            default: begin
                for (int i = 0; i < LANES; i++) begin
                    if (int'(i_rd_sel) == int'(SEL_LANE0) + i) w_rd_mux = w_lane_q[i];
                end
            end
        endcase
    end

    // An outstanding ack blocks acceptance, so a held request acks every other cycle.
    assign w_accept = i_rd_req & ~r_rd_ack;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_ack <= w_accept;
            if (w_accept) r_rd_data <= w_rd_mux;
        end
    end

    assign o_report  = (r_state == ST_REPORT) ? r_halt_mask : '0;
    assign o_done    = (r_state == ST_DONE);
    assign o_rd_ack  = r_rd_ack;
    assign o_rd_data = r_rd_data;

endmodule
